// File: rtl/nzet_scatter.sv
// Sparse-to-dense scatter-accumulator: returns 2-of-4 compacted beats to their
// dense lanes, sums them per group and emits one dense result per group.
module nzet_scatter #(
  parameter int W  = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_mask,
  input  logic [W-1:0]  in_v0,
  input  logic [W-1:0]  in_v1,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_d0,
  output logic [W-1:0]  out_d1,
  output logic [W-1:0]  out_d2,
  output logic [W-1:0]  out_d3,
  output logic [CW-1:0] out_beats,
  output logic          out_err
);

  typedef enum logic {IDLE, FULL} state_t;

  state_t        state, state_nx;
  logic [W-1:0]  acc  [4];
  logic [W-1:0]  dout [4];
  logic [W-1:0]  scat [4];
  logic [W-1:0]  sum  [4];
  logic [CW-1:0] gcnt;
  logic          gerr;
  logic          has0, has1, bad, take;
  logic [1:0]    idx0, idx1;
  logic [2:0]    pop;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
    return (x == {CW{1'b1}}) ? x : x + 1'b1;
  endfunction

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign take      = in_valid && in_ready;

  // Locate the two lowest set mask bits and route the values there.
  always_comb begin
    has0 = 1'b0;
    has1 = 1'b0;
    idx0 = 2'd0;
    idx1 = 2'd0;
    pop  = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (in_mask[i]) begin
        pop = pop + 3'd1;
        if (!has0) begin
          has0 = 1'b1;
          idx0 = 2'(i);
        end else if (!has1) begin
          has1 = 1'b1;
          idx1 = 2'(i);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      scat[i] = '0;
      if (has0 && idx0 == 2'(i) && idx0 != 2'd3) scat[i] = in_v0;
      if (has1 && idx1 == 2'(i))                 scat[i] = in_v1;
      sum[i] = acc[i] + scat[i];
    end
    bad = (pop != 3'd2) || (has0 && idx0 == 2'd3);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (take && in_last) state_nx = FULL;
      FULL: if (take && in_last) state_nx = FULL;
            else if (out_ready)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Accumulator / output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        acc[i]  <= '0;
        dout[i] <= '0;
      end
      gcnt      <= '0;
      gerr      <= 1'b0;
      out_beats <= '0;
      out_err   <= 1'b0;
    end else if (take) begin
      if (in_last) begin
        for (int i = 0; i < 4; i++) begin
          dout[i] <= sum[i];
          acc[i]  <= '0;
        end
        out_beats <= sat_inc(gcnt);
        out_err   <= gerr | bad;
        gcnt      <= '0;
        gerr      <= 1'b0;
      end else begin
        for (int i = 0; i < 4; i++) acc[i] <= sum[i];
        gcnt <= sat_inc(gcnt);
        gerr <= gerr | bad;
      end
    end
  end

  assign out_d0 = dout[0];
  assign out_d1 = dout[1];
  assign out_d2 = dout[2];
  assign out_d3 = dout[3];

endmodule

// File: tb/tb_nzet_scatter.sv
// Randomized bench for nzet_scatter against a per-group reference model;
// a CW=2 twin shares the stimulus to exercise beat-count saturation.
module tb_nzet_scatter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_mask = '0;
  logic [15:0] in_v0 = '0;
  logic [15:0] in_v1 = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_err;
  logic [15:0] out_d0, out_d1, out_d2, out_d3;
  logic [7:0]  out_beats;
  logic        s_in_ready, s_out_valid, s_out_err;
  logic [15:0] s_d0, s_d1, s_d2, s_d3;
  logic [1:0]  s_out_beats;

  always #5 clk = ~clk;

  nzet_scatter #(.W(16), .CW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mask(in_mask), .in_v0(in_v0), .in_v1(in_v1), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_d0(out_d0), .out_d1(out_d1), .out_d2(out_d2), .out_d3(out_d3),
    .out_beats(out_beats), .out_err(out_err)
  );

  nzet_scatter #(.W(16), .CW(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_mask(in_mask), .in_v0(in_v0), .in_v1(in_v1), .in_last(in_last),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_d0(s_d0), .out_d1(s_d1), .out_d2(s_d2), .out_d3(s_d3),
    .out_beats(s_out_beats), .out_err(s_out_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: running group sums and the last emitted result.
  logic [15:0] macc [4];
  logic [15:0] mout [4];
  logic [15:0] sc_lane [4];
  bit          sc_err;
  int          mcnt;
  bit          mgerr, merr_o, mvalid;
  logic [7:0]  mb;
  logic [1:0]  mb2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void mscatter(input logic [3:0] m, input logic [15:0] a, input logic [15:0] b);
    int pos[$];
    for (int i = 0; i < 4; i++) if (m[i]) pos.push_back(i);
    for (int i = 0; i < 4; i++) sc_lane[i] = 16'h0;
    if (pos.size() >= 1 && pos[0] < 3) sc_lane[pos[0]] = a;
    if (pos.size() >= 2) sc_lane[pos[1]] = b;
    sc_err = (pos.size() != 2);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      macc[i] = 16'h0;
      mout[i] = 16'h0;
    end
    mcnt = 0; mgerr = 0; merr_o = 0; mvalid = 0; mb = 0; mb2 = 0;
  endfunction

  task automatic check_outputs();
    check("out_valid", out_valid, mvalid);
    check("out_d0", out_d0, mout[0]);
    check("out_d1", out_d1, mout[1]);
    check("out_d2", out_d2, mout[2]);
    check("out_d3", out_d3, mout[3]);
    check("out_beats", out_beats, mb);
    check("out_err", out_err, merr_o);
    check("sat_beats", s_out_beats, mb2);
  endtask

  task automatic cycle(input bit v, input logic [3:0] m, input logic [15:0] a,
                       input logic [15:0] b, input bit l, input bit r);
    bit take;
    int total;
    @(negedge clk);
    in_valid = v; in_mask = m; in_v0 = a; in_v1 = b; in_last = l; out_ready = r;
    #1;
    check("in_ready", in_ready, !mvalid || r);
    take = v && (!mvalid || r);
    @(posedge clk);
    if (mvalid && r) mvalid = 0;
    if (take) begin
      mscatter(m, a, b);
      mcnt++;
      mgerr = mgerr | sc_err;
      for (int i = 0; i < 4; i++) macc[i] = macc[i] + sc_lane[i];
      if (l) begin
        total = mcnt;
        for (int i = 0; i < 4; i++) begin
          mout[i] = macc[i];
          macc[i] = 16'h0;
        end
        mb     = (total > 255) ? 8'd255 : 8'(total);
        mb2    = (total > 3) ? 2'd3 : 2'(total);
        merr_o = mgerr;
        mvalid = 1;
        mcnt   = 0;
        mgerr  = 0;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    in_valid = 0; in_last = 0; out_ready = 0;
    #2 rst = 1;
    #1;
    model_reset();
    check_outputs();
    check("rst_in_ready", in_ready, 1'b1);
    #1 rst = 0;
  endtask

  logic [3:0] good [6] = '{4'b0011, 4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1100};

  initial begin
    logic [3:0] m;
    model_reset();
    #1 rst = 1;
    #1;
    check_outputs();
    check("reset_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;

    // Single beat, normal mask
    cycle(1, 4'b0110, 16'h0011, 16'h0022, 1, 1);
    check("t1_d1", out_d1, 16'h0011);
    check("t1_d2", out_d2, 16'h0022);
    check("t1_beats", out_beats, 8'd1);

    // Three-beat group, then a group that must start from zero
    cycle(1, 4'b0011, 16'd5, 16'd7, 0, 1);
    cycle(1, 4'b1001, 16'd1, 16'd2, 0, 1);
    cycle(1, 4'b1100, 16'd3, 16'd4, 1, 1);
    check("t2_d0", out_d0, 16'd6);
    check("t2_d3", out_d3, 16'd6);
    check("t2_beats", out_beats, 8'd3);
    cycle(1, 4'b1010, 16'd10, 16'd20, 1, 1);
    check("t2_next_d1", out_d1, 16'd10);

    // Malformed masks
    cycle(1, 4'b1000, 16'h1234, 16'h5678, 1, 1);
    check("t3_lone3_err", out_err, 1'b1);
    check("t3_lone3_d3", out_d3, 16'h0);
    cycle(1, 4'b0111, 16'd9, 16'd8, 1, 1);
    check("t3_three_d0", out_d0, 16'd9);
    check("t3_three_d2", out_d2, 16'd0);
    cycle(1, 4'b0000, 16'hAAAA, 16'hBBBB, 1, 1);
    check("t3_zero_err", out_err, 1'b1);

    // Wrap-around and beat-count saturation
    cycle(1, 4'b0101, 16'hFFFF, 16'h8000, 0, 1);
    cycle(1, 4'b0101, 16'hFFFF, 16'h8000, 1, 1);
    check("t4_d0", out_d0, 16'hFFFE);
    check("t4_d2", out_d2, 16'h0000);
    for (int i = 0; i < 5; i++) cycle(1, 4'b0011, 16'd1, 16'd1, i == 4, 1);
    check("t4_sat", s_out_beats, 2'd3);
    check("t4_nosat", out_beats, 8'd5);

    // Backpressure, then transfer with a simultaneous new last beat
    for (int i = 0; i < 5; i++) cycle(1, 4'b0110, 16'd99, 16'd98, 1, 0);
    check("t5_hold_d0", out_d0, 16'd5);
    cycle(1, 4'b1001, 16'h0101, 16'h0202, 1, 1);
    check("t5_valid", out_valid, 1'b1);
    check("t5_new_d3", out_d3, 16'h0202);

    // Reset mid-group discards the partial sums
    cycle(1, 4'b0011, 16'h0100, 16'h0200, 0, 1);
    cycle(1, 4'b0011, 16'h0100, 16'h0200, 0, 1);
    pulse_reset();
    cycle(1, 4'b0011, 16'h0003, 16'h0004, 1, 1);
    check("t6_d0", out_d0, 16'h0003);
    check("t6_beats", out_beats, 8'd1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      m = ($urandom_range(0, 9) == 0) ? 4'($urandom) : good[$urandom_range(0, 5)];
      cycle($urandom_range(0, 9) < 8, m, 16'($urandom), 16'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7);
      if (n == 1500) pulse_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
